// File: rtl/mcpu_pkg.sv
// mcpu_pkg: shared definitions for the multi-cycle MIPS controller.
// Holds the FSM state encodings, opcode/funct constants, ALU_Control
// encodings and the datapath mux select encodings.
package mcpu_pkg;

    typedef enum logic [4:0] {
        S_IF     = 5'd0,
        S_ID     = 5'd1,
        S_EX_R   = 5'd2,
        S_WB_R   = 5'd3,
        S_EX_MA  = 5'd4,
        S_MEM_RD = 5'd5,
        S_MEM_WR = 5'd6,
        S_WB_LW  = 5'd7,
        S_EX_BR  = 5'd8,
        S_EX_J   = 5'd9,
        S_EX_JAL = 5'd10,
        S_EX_JR  = 5'd11,
        S_EX_I   = 5'd12,
        S_WB_I   = 5'd13,
        S_WB_LUI = 5'd14,
        S_ILL    = 5'd15
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_NOR = 6'b100111;
    localparam logic [5:0] F_XOR = 6'b100110;
    localparam logic [5:0] F_SRL = 6'b000010;
    localparam logic [5:0] F_JR  = 6'b001000;

    // ALU_Control encodings
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // RegDst
    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    // MemtoReg
    localparam logic [1:0] MR_ALU = 2'b00;
    localparam logic [1:0] MR_MDR = 2'b01;
    localparam logic [1:0] MR_LUI = 2'b10;
    localparam logic [1:0] MR_PC  = 2'b11;

    // ALUSrcB
    localparam logic [1:0] SB_B      = 2'b00;
    localparam logic [1:0] SB_FOUR   = 2'b01;
    localparam logic [1:0] SB_IMM    = 2'b10;
    localparam logic [1:0] SB_IMM_SH = 2'b11;

    // PCSource
    localparam logic [1:0] PS_ALU    = 2'b00;
    localparam logic [1:0] PS_ALUOUT = 2'b01;
    localparam logic [1:0] PS_JUMP   = 2'b10;
    localparam logic [1:0] PS_REG    = 2'b11;

endpackage

// File: rtl/mcpu_alu_dec.sv
// mcpu_alu_dec: combinational ALU operation decoder.
// Ports:
//   OPcode   in  6  IR[31:26]
//   Fun      in  6  IR[5:0]
//   alu_ctrl out 3  ALU_Control for R-type (by Fun) or I-type ALU ops (by OPcode)
// Undecoded combinations fall back to add.
module mcpu_alu_dec
    import mcpu_pkg::*;
(
    input  logic [5:0] OPcode,
    input  logic [5:0] Fun,
    output logic [2:0] alu_ctrl
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        if (OPcode == OP_RTYPE) begin
            case (Fun)
                F_ADD:   alu_ctrl = ALU_ADD;
                F_SUB:   alu_ctrl = ALU_SUB;
                F_AND:   alu_ctrl = ALU_AND;
                F_OR:    alu_ctrl = ALU_OR;
                F_SLT:   alu_ctrl = ALU_SLT;
                F_NOR:   alu_ctrl = ALU_NOR;
                F_XOR:   alu_ctrl = ALU_XOR;
                F_SRL:   alu_ctrl = ALU_SRL;
                default: alu_ctrl = ALU_ADD;
            endcase
        end else begin
            case (OPcode)
                OP_ADDI: alu_ctrl = ALU_ADD;
                OP_ANDI: alu_ctrl = ALU_AND;
                OP_ORI:  alu_ctrl = ALU_OR;
                OP_SLTI: alu_ctrl = ALU_SLT;
                OP_XORI: alu_ctrl = ALU_XOR;
                default: alu_ctrl = ALU_ADD;
            endcase
        end
    end

endmodule

// File: rtl/mcpu_ctrl_fsm.sv
// mcpu_ctrl_fsm: multi-cycle MIPS controller FSM.
// Sequences fetch / decode / execute / memory / writeback for a shared-memory
// datapath and stalls on MIO_ready in IF, MEM_RD and MEM_WR.
// Ports:
//   clk, rst_n (async, active-low)
//   OPcode, Fun   IR fields (IR is stable from ID until the next fetch)
//   zero          ALU zero flag, used for beq/bne resolution
//   MIO_ready     memory access complete this cycle
//   PCWrite, IorD, MemRead, MemWrite, IRWrite, CPU_MIO, RegDst, MemtoReg,
//   ALUSrcA, ALUSrcB, ALU_Control, PCSource, RegWrite  datapath controls
//   illegal_op    undecoded opcode seen
//   state_out     current state for debug display
// Build option: MCPU_CTRL_ERR_TRAP_EN makes ILL a sink state until reset;
// without it ILL is a one-cycle NOP that pulses illegal_op.
module mcpu_ctrl_fsm
    import mcpu_pkg::*;
#(
    parameter int STATE_W = 5
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         OPcode,
    input  logic [5:0]         Fun,
    input  logic               zero,
    input  logic               MIO_ready,
    output logic               PCWrite,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               CPU_MIO,
    output logic [1:0]         RegDst,
    output logic [1:0]         MemtoReg,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [2:0]         ALU_Control,
    output logic [1:0]         PCSource,
    output logic               RegWrite,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_out
);

    state_t     state;
    logic [2:0] alu_dec_ctrl;

    mcpu_alu_dec u_alu_dec (
        .OPcode   (OPcode),
        .Fun      (Fun),
        .alu_ctrl (alu_dec_ctrl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IF;
        end else begin
            case (state)
                S_IF:     if (MIO_ready) state <= S_ID;
                S_ID: begin
                    case (OPcode)
                        OP_RTYPE: state <= (Fun == F_JR) ? S_EX_JR : S_EX_R;
                        OP_LW, OP_SW:   state <= S_EX_MA;
                        OP_BEQ, OP_BNE: state <= S_EX_BR;
                        OP_J:     state <= S_EX_J;
                        OP_JAL:   state <= S_EX_JAL;
                        OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_XORI: state <= S_EX_I;
                        OP_LUI:   state <= S_WB_LUI;
                        default:  state <= S_ILL;
                    endcase
                end
                S_EX_R:   state <= S_WB_R;
                S_EX_MA:  state <= (OPcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD: if (MIO_ready) state <= S_WB_LW;
                S_MEM_WR: if (MIO_ready) state <= S_IF;
                S_EX_I:   state <= S_WB_I;
`ifdef MCPU_CTRL_ERR_TRAP_EN
                S_ILL:    state <= S_ILL;
`else
                S_ILL:    state <= S_IF;
`endif
                // WB_R, WB_LW, EX_BR, EX_J, EX_JAL, EX_JR, WB_I, WB_LUI and
                // any unused encoding all return to fetch.
                default:  state <= S_IF;
            endcase
        end
    end

    // Moore decode of the state register; IF fetch strobes follow MIO_ready,
    // EX_R takes its ALU op from Fun and EX_BR resolves on zero.
    always_comb begin
        PCWrite     = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = RD_RT;
        MemtoReg    = MR_ALU;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SB_B;
        ALU_Control = ALU_AND;
        PCSource    = PS_ALU;
        RegWrite    = 1'b0;
        illegal_op  = 1'b0;
        case (state)
            S_IF: begin
                MemRead     = 1'b1;
                ALUSrcB     = SB_FOUR;
                ALU_Control = ALU_ADD;
                IRWrite     = MIO_ready;
                PCWrite     = MIO_ready;
            end
            S_ID: begin
                ALUSrcB     = SB_IMM_SH;
                ALU_Control = ALU_ADD;
            end
            S_EX_R: begin
                ALUSrcA     = 1'b1;
                ALU_Control = alu_dec_ctrl;
            end
            S_WB_R: begin
                RegDst   = RD_RD;
                RegWrite = 1'b1;
            end
            S_EX_MA: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = SB_IMM;
                ALU_Control = ALU_ADD;
            end
            S_MEM_RD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            S_MEM_WR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_WB_LW: begin
                MemtoReg = MR_MDR;
                RegWrite = 1'b1;
            end
            S_EX_BR: begin
                ALUSrcA     = 1'b1;
                ALU_Control = ALU_SUB;
                PCSource    = PS_ALUOUT;
                PCWrite     = (OPcode == OP_BNE) ? ~zero : zero;
            end
            S_EX_J: begin
                PCSource = PS_JUMP;
                PCWrite  = 1'b1;
            end
            S_EX_JAL: begin
                PCSource = PS_JUMP;
                PCWrite  = 1'b1;
                RegDst   = RD_RA;
                MemtoReg = MR_PC;
                RegWrite = 1'b1;
            end
            S_EX_JR: begin
                PCSource = PS_REG;
                PCWrite  = 1'b1;
            end
            S_EX_I: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = SB_IMM;
                ALU_Control = alu_dec_ctrl;
            end
            S_WB_I: begin
                RegWrite = 1'b1;
            end
            S_WB_LUI: begin
                MemtoReg = MR_LUI;
                RegWrite = 1'b1;
            end
            S_ILL: begin
                illegal_op = 1'b1;
            end
            default: ;
        endcase
        // While reset is held the bus sees a quiet fetch: nothing is written,
        // so an instruction aborted by reset cannot complete any write.
        if (!rst_n) begin
            PCWrite     = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b1;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            RegDst      = 2'b00;
            MemtoReg    = 2'b00;
            ALUSrcA     = 1'b0;
            ALUSrcB     = 2'b00;
            ALU_Control = 3'b000;
            PCSource    = 2'b00;
            RegWrite    = 1'b0;
            illegal_op  = 1'b0;
        end
    end

    assign CPU_MIO   = MemRead | MemWrite;
    assign state_out = STATE_W'(state);

endmodule

// File: doc/mcpu_ctrl_fsm.md
Name: mcpu_ctrl_fsm

Overview:
- Multi-cycle MIPS controller FSM. Sequences the shared-memory multi-cycle datapath: fetch, decode, execute, memory and writeback.
- Sits beside the datapath and MIO bus bridge. Takes OPcode/Fun from the IR and zero from the ALU; drives all datapath enables and muxes.
- Stalls on MIO_ready for every memory access.

Parameters:
- STATE_W, 5, width of the state register and of state_out.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- OPcode  in  6  IR[31:26]
- Fun  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- MIO_ready  in  1  memory/IO access complete this cycle
- PCWrite  out  1  PC load enable, branch resolution folded in
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- CPU_MIO  out  1  bus request (MemRead | MemWrite)
- RegDst  out  2  write register: 00 = rt, 01 = rd, 10 = $31
- MemtoReg  out  2  write data: 00 = ALUOut, 01 = MDR, 10 = {imm,16'b0}, 11 = PC
- ALUSrcA  out  1  0 = PC, 1 = A
- ALUSrcB  out  2  00 = B, 01 = 4, 10 = sext imm, 11 = sext imm << 2
- ALU_Control  out  3  000 and, 001 or, 010 add, 110 sub, 111 slt, 100 nor, 011 xor, 101 srl
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = A (jr)
- RegWrite  out  1  register file write enable
- illegal_op  out  1  undecoded opcode/funct seen (see Optional Feature)
- state_out  out  STATE_W  current state, for debug display

Behaviour:
- Outputs are Moore: decoded from the state register only. Exceptions: ALU_Control in EX_R depends on Fun; PCWrite in EX_BR depends on zero.
- Reset (rst_n low, asynchronous): state = IF. While rst_n is low, every 1-bit output and every bus output is 0, except MemRead = 1 and CPU_MIO = 1 (IF decode, with IRWrite and PCWrite forced 0).
- Reset mid-operation aborts the instruction immediately. No partial write may complete after reset is asserted.
- States and transitions:
  - IF: MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, add, PCSource = 00. IRWrite and PCWrite equal MIO_ready. Hold until MIO_ready, then go to ID.
  - ID: ALUSrcA = 0, ALUSrcB = 11, add (branch target into ALUOut). Dispatch on OPcode:
    - 000000 → EX_R; funct 001000 → EX_JR
    - 100011 / 101011 → EX_MA
    - 000100 / 000101 → EX_BR
    - 000010 → EX_J; 000011 → EX_JAL
    - 001000 / 001100 / 001101 / 001010 / 001110 → EX_I
    - 001111 → WB_LUI
    - any other → ILL
  - EX_R: ALUSrcA = 1, ALUSrcB = 00. ALU_Control by Fun: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 100111 nor, 100110 xor, 000010 srl. → WB_R.
  - WB_R: RegDst = 01, MemtoReg = 00, RegWrite = 1. → IF.
  - EX_MA: ALUSrcA = 1, ALUSrcB = 10, add. lw → MEM_RD, sw → MEM_WR.
  - MEM_RD: IorD = 1, MemRead = 1. Hold until MIO_ready, then → WB_LW.
  - MEM_WR: IorD = 1, MemWrite = 1 for every cycle in state. Hold until MIO_ready, then → IF.
  - WB_LW: RegDst = 00, MemtoReg = 01, RegWrite = 1. → IF.
  - EX_BR: ALUSrcA = 1, ALUSrcB = 00, sub, PCSource = 01. PCWrite = zero for beq, ~zero for bne. → IF.
  - EX_J: PCSource = 10, PCWrite = 1. → IF.
  - EX_JAL: PCSource = 10, PCWrite = 1, RegDst = 10, MemtoReg = 11, RegWrite = 1. → IF.
  - EX_JR: PCSource = 11, PCWrite = 1. → IF.
  - EX_I: ALUSrcA = 1, ALUSrcB = 10. ALU op: addi add, andi and, ori or, slti slt, xori xor. → WB_I.
  - WB_I: RegDst = 00, MemtoReg = 00, RegWrite = 1. → IF.
  - WB_LUI: RegDst = 00, MemtoReg = 10, RegWrite = 1. → IF.
- CPI with MIO_ready high:
  - 3: beq, bne, j, jal, jr
  - 4: R-type, I-type, sw
  - 5: lw
  - lui takes 3.
- Each cycle MIO_ready is low in IF, MEM_RD or MEM_WR adds one cycle. MIO_ready is ignored in all other states.
- Unused state encodings → IF on the next clock.

Optional Feature:
- Macro MCPU_CTRL_ERR_TRAP_EN.
- Defined: ILL is a sink state. illegal_op = 1, all write enables are 0, and the FSM stays in ILL until reset.
- Undefined: ILL behaves as a NOP and returns to IF next cycle; illegal_op pulses high for that single cycle.

Decomposition:
- Shared package mcpu_pkg holds: state encodings, opcode and funct constants, ALU_Control encodings, and the RegDst/MemtoReg/ALUSrcB/PCSource select encodings.
- One sub-module, mcpu_alu_dec: combinational Fun/OPcode → ALU_Control, reused by EX_R and EX_I.

Test Plan:
- Reset held low 3 cycles, released:
  - state_out = IF while held; MemRead = 1; IRWrite = 0; PCWrite = 0.
  - First rising edge with MIO_ready = 1 gives IRWrite = 1 and PCWrite = 1.
- lw (OPcode 100011), MIO_ready = 1 throughout:
  - States IF, ID, EX_MA, MEM_RD, WB_LW, IF.
  - WB_LW shows RegWrite = 1, MemtoReg = 01, RegDst = 00.
- sw with MIO_ready low for 3 cycles in MEM_WR:
  - MemWrite = 1 for 4 cycles; state then IF. Total 7 cycles.
- beq with zero = 1, then zero = 0:
  - EX_BR PCWrite = 1, then 0. PCSource = 01 and ALU_Control = 110 in both.
- jal:
  - EX_JAL asserts PCWrite = 1, RegWrite = 1, RegDst = 10, MemtoReg = 11. Returns to IF after 3 cycles.
- OPcode 111111 with MCPU_CTRL_ERR_TRAP_EN defined:
  - FSM parks in ILL, illegal_op = 1, RegWrite = 0, MemWrite = 0 for 20 cycles.
  - rst_n low then high returns the FSM to IF.
